mem_stage: RTL



---
 rtl/mem_stage_pkg.sv | 39 +++
 rtl/load_ext.sv | 25 ++
 rtl/mem_stage.sv | 115 +++++++++++
 3 files changed

// File: rtl/mem_stage_pkg.sv
// Shared encodings for the memory-access stage: op classes, access widths,
// load/store opcodes and the stage FSM state type.
package mem_stage_pkg;

  localparam logic [2:0] STAT_BUBBLE = 3'b000;
  localparam logic [2:0] STAT_REG    = 3'b001;
  localparam logic [2:0] STAT_STORE  = 3'b010;
  localparam logic [2:0] STAT_LOAD   = 3'b011;
  localparam logic [2:0] STAT_BRANCH = 3'b100;
  localparam logic [2:0] STAT_JUMP   = 3'b101;

  localparam logic [1:0] W_BYTE = 2'b00;
  localparam logic [1:0] W_HALF = 2'b01;
  localparam logic [1:0] W_WORD = 2'b10;

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SW  = 6'h2B;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_e;

  // Access size implied by a load/store opcode; anything else is a word access.
  function automatic logic [1:0] op_width(input logic [5:0] op);
    case (op)
      OP_LB, OP_LBU, OP_SB: op_width = W_BYTE;
      OP_LH, OP_LHU, OP_SH: op_width = W_HALF;
      default:              op_width = W_WORD;
    endcase
  endfunction

endpackage

// File: rtl/load_ext.sv
// Load data extension: selects and sign/zero-extends the loaded byte or
// halfword according to the load opcode. Purely combinational.
module load_ext
  import mem_stage_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [5:0]        op,
  input  logic [DATA_W-1:0] rdata,
  output logic [DATA_W-1:0] ext
);

  // Extend the low byte/half as the opcode demands; LW and others pass through.
  always_comb begin
    ext = rdata;
    case (op)
      OP_LB:   ext = {{(DATA_W-8){rdata[7]}}, rdata[7:0]};
      OP_LBU:  ext = {{(DATA_W-8){1'b0}}, rdata[7:0]};
      OP_LH:   ext = {{(DATA_W-16){rdata[15]}}, rdata[15:0]};
      OP_LHU:  ext = {{(DATA_W-16){1'b0}}, rdata[15:0]};
      default: ext = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: passes register results to writeback after one cycle,
// runs loads/stores over a level req/done handshake and stalls upstream
// while an access is outstanding.
//
//   state  | meaning
//   S_IDLE | no access outstanding; accepts the op in the EX/MEM latch
//   S_WAIT | access issued, mem_req held until the controller's mem_done
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [2:0]        status_in,
  input  logic [5:0]        op_in,
  input  logic [ADDR_W-1:0] mem_addr_in,
  input  logic [DATA_W-1:0] data_in,
  input  logic [4:0]        rd_in,
  input  logic              mem_done,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [1:0]        mem_width,
  output logic              stall_req,
  output logic              wb_we,
  output logic [4:0]        wb_rd,
  output logic [DATA_W-1:0] wb_data
);

  state_e            state, state_nxt;
  logic [5:0]        acc_op;
  logic [4:0]        acc_rd;
  logic [DATA_W-1:0] ld_ext;
  logic              is_mem_op;
  logic              is_reg_op;

  assign is_mem_op = (status_in == STAT_STORE) || (status_in == STAT_LOAD);
  assign is_reg_op = (status_in == STAT_REG) || (status_in == STAT_JUMP);

  load_ext #(.DATA_W(DATA_W)) u_load_ext (
    .op    (acc_op),
    .rdata (mem_rdata),
    .ext   (ld_ext)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next state and combinational handshake outputs.
  always_comb begin
    state_nxt = state;
    mem_req   = 1'b0;
    stall_req = 1'b0;
    case (state)
      S_IDLE: begin
        stall_req = is_mem_op;
        if (is_mem_op) state_nxt = S_WAIT;
      end
      S_WAIT: begin
        mem_req   = 1'b1;
        // Release upstream on the completing edge so it advances in lock-step.
        stall_req = !mem_done;
        if (mem_done) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Capture the access on entry to WAIT; values stay stable until the next access.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_width <= W_BYTE;
      acc_op    <= '0;
      acc_rd    <= '0;
    end else if (state == S_IDLE && is_mem_op) begin
      mem_we    <= (status_in == STAT_STORE);
      mem_addr  <= mem_addr_in;
      mem_wdata <= data_in;
      mem_width <= op_width(op_in);
      acc_op    <= op_in;
      acc_rd    <= rd_in;
    end
  end

  // Writeback register: results and completed loads, never to x0.
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_we   <= 1'b0;
      wb_rd   <= '0;
      wb_data <= '0;
    end else begin
      wb_we <= 1'b0;
      if (state == S_IDLE && is_reg_op) begin
        wb_we   <= (rd_in != 5'd0);
        wb_rd   <= rd_in;
        wb_data <= data_in;
      end else if (state == S_WAIT && mem_done && !mem_we) begin
        wb_we   <= (acc_rd != 5'd0);
        wb_rd   <= acc_rd;
        wb_data <= ld_ext;
      end
    end
  end

endmodule
